// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default FIFO depth, line levels and
// a width helper used by the transmitter, receiver and their buffers.
package uart_pkg;

   localparam int unsigned UART_DATA_W     = 8;
   localparam int unsigned UART_FIFO_DEPTH = 16;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam logic IDLE      = 1'b1;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;

   // Smallest r with 2**r >= v; usable in constant expressions.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the TX FIFO: synchronous write port, asynchronous read
// port so the head entry is visible without a read cycle.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W = UART_DATA_W,
   parameter int unsigned DEPTH  = UART_FIFO_DEPTH,
   parameter int unsigned ADDR_W = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_byte_fifo.sv
// Show-ahead byte FIFO feeding the UART transmitter, with level flags and a
// sticky overflow flag; all flags come from the registered occupancy count.
module uart_tx_byte_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W    = UART_DATA_W,
   parameter int unsigned DEPTH     = UART_FIFO_DEPTH,
   parameter int unsigned AFULL_LVL = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [clog2(DEPTH+1)-1:0]  count,
   output logic                       full,
   output logic                       empty,
   output logic                       afull,
   output logic                       overflow
);

   localparam int unsigned PTR_W = clog2(DEPTH);
   localparam int unsigned CNT_W = clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LVL);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;

   always_comb begin
      full     = (count == FULL_CNT);
      empty    = (count == '0);
      afull    = (count >= AFULL_CNT);
      wr_ready = !full;
      rd_valid = !empty;
      push     = wr_valid && wr_ready;
      pop      = rd_valid && rd_ready;
   end

   // Pointers wrap naturally since DEPTH is a power of two; fullness is
   // tracked by count so equal pointers are never ambiguous.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         if (wr_valid && full) overflow <= 1'b1;
      end
   end

   uart_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (PTR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

endmodule
